// File: rtl/fan_tick_gen.sv
// -----------------------------------------------------------------------------
// fan_tick_gen
// Purpose : Locks onto a once-per-revolution hall sensor and produces 360
//           evenly spread one-cycle degree ticks per revolution for the
//           downstream LED pattern stage.
//
// Ports   :
//   clk     in   1      single clock, all state on rising edge
//   rst     in   1      asynchronous active-low reset
//   hall    in   1      raw magnet sensor (async to clk), rising edge = rev start
//   fanclk  out  1      one-cycle degree tick, 360 per revolution while locked
//   index   out  1      one-cycle pulse on each accepted hall edge while locked
//   locked  out  1      high while the tracker is in RUN
//   period  out  CNT_W  last valid revolution period in clk cycles (0 = none)
//   deg     out  9      ticks issued since the last accepted edge, 0..360
// -----------------------------------------------------------------------------
module fan_tick_gen #(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned MIN_GAP    = 1000,
  parameter int unsigned MIN_PERIOD = 720,
  parameter int unsigned MAX_PERIOD = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hall,
  output logic             fanclk,
  output logic             index,
  output logic             locked,
  output logic [CNT_W-1:0] period,
  output logic [8:0]       deg
);

  localparam int unsigned ACC_W = CNT_W + 1;
  localparam int unsigned DEG_W = 9;

  localparam logic [ACC_W-1:0] TICK_STEP  = ACC_W'(360);
  localparam logic [DEG_W-1:0] DEG_MAX    = DEG_W'(360);
  localparam logic [CNT_W-1:0] GAP_SAT    = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(MAX_PERIOD - 1);
  localparam logic [ACC_W-1:0] GAP_MIN    = ACC_W'(MIN_GAP);
  localparam logic [ACC_W-1:0] PER_MIN    = ACC_W'(MIN_PERIOD);
  localparam logic [ACC_W-1:0] PER_MAX    = ACC_W'(MAX_PERIOD);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic [1:0]       r_arm;
  state_t           r_state;
  logic [CNT_W-1:0] r_gap_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [DEG_W-1:0] r_deg;
  logic [CNT_W-1:0] r_period;
  logic             r_fanclk;
  logic             r_index;
  logic             r_locked;

  // ---------------------------------------------------------------------------
  // Decode wires
  // ---------------------------------------------------------------------------
  logic             w_rise;
  logic [ACC_W-1:0] w_gap_p1;
  logic             w_gap_ok;
  logic             w_accept;
  logic             w_in_range;
  logic             w_timeout;
  logic [ACC_W-1:0] w_per_ext;
  logic [ACC_W-1:0] w_acc_sum;
  logic [ACC_W-1:0] w_acc_next;
  logic [ACC_W-1:0] w_acc_look;
  logic             w_tick_next;

  // Synchronizer, edge-detect history and arming counter.
  // The arming counter holds off edge detection until the history flop
  // carries a genuine hall sample, so a level already high at reset
  // release is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_arm   <= 2'd0;
    end else begin
      r_sync1 <= hall;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (r_arm != 2'd3) begin
        r_arm <= r_arm + 2'd1;
      end
    end
  end

  assign w_rise = r_sync2 & ~r_sync3 & (r_arm == 2'd3);

  // Edge qualification, period range and tick-scheduling arithmetic.
  always_comb begin
    w_gap_p1   = ACC_W'(r_gap_cnt) + ACC_W'(1);
    // No previous accepted edge exists in IDLE, so the gap filter is moot.
    w_gap_ok   = (r_state == ST_IDLE) || (w_gap_p1 >= GAP_MIN);
    w_accept   = w_rise && w_gap_ok;
    w_in_range = (w_gap_p1 >= PER_MIN) && (w_gap_p1 < PER_MAX);
    // Fires on the last cycle before gap_cnt saturates, so the tracker is
    // idle exactly when gap_cnt reaches MAX_PERIOD.
    w_timeout  = (r_state != ST_IDLE) && (r_gap_cnt == GAP_LAST);

    w_per_ext  = ACC_W'(r_period);
    w_acc_sum  = r_acc + TICK_STEP;
    w_acc_next = (w_acc_sum >= w_per_ext) ? (w_acc_sum - w_per_ext) : w_acc_sum;
    // fanclk is registered, so decide one cycle ahead whether the next
    // cycle's accumulator step crosses the period.
    w_acc_look  = w_acc_next + TICK_STEP;
    w_tick_next = (w_acc_look >= w_per_ext) && (r_deg != DEG_MAX);
  end

  // Tracker FSM with gap counter, phase accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      r_acc     <= '0;
      r_deg     <= '0;
      r_period  <= '0;
      r_fanclk  <= 1'b0;
      r_index   <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_fanclk <= 1'b0;
      r_index  <= 1'b0;

      if (w_accept) begin
        r_gap_cnt <= '0;
      end else if (r_gap_cnt != GAP_SAT) begin
        r_gap_cnt <= r_gap_cnt + CNT_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          r_acc    <= '0;
          r_locked <= 1'b0;
          if (w_accept) begin
            r_state <= ST_ACQUIRE;
            r_deg   <= '0;
          end
        end

        ST_ACQUIRE: begin
          r_acc <= '0;
          if (w_accept) begin
            r_deg <= '0;
            if (w_in_range) begin
              r_state  <= ST_RUN;
              r_locked <= 1'b1;
              r_period <= CNT_W'(w_gap_p1);
              r_index  <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state  <= ST_IDLE;
            r_period <= '0;
            r_deg    <= '0;
          end
        end

        ST_RUN: begin
          if (w_accept) begin
            // A new revolution restarts phase; any tick due now is dropped.
            r_acc <= '0;
            r_deg <= '0;
            if (w_in_range) begin
              r_period <= CNT_W'(w_gap_p1);
              r_index  <= 1'b1;
            end else begin
              r_state  <= ST_ACQUIRE;
              r_locked <= 1'b0;
            end
          end else if (w_timeout) begin
            r_state  <= ST_IDLE;
            r_locked <= 1'b0;
            r_period <= '0;
            r_deg    <= '0;
            r_acc    <= '0;
          end else begin
            r_acc <= w_acc_next;
            if (w_tick_next) begin
              r_fanclk <= 1'b1;
              r_deg    <= r_deg + DEG_W'(1);
            end
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_locked <= 1'b0;
          r_acc    <= '0;
          r_deg    <= '0;
          r_period <= '0;
        end
      endcase
    end
  end

  assign fanclk = r_fanclk;
  assign index  = r_index;
  assign locked = r_locked;
  assign period = r_period;
  assign deg    = r_deg;

endmodule

// File: tb/tb_fan_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_fan_tick_gen
// Directed bench for fan_tick_gen. Each revolution window starts on the cycle
// the previous accepted edge becomes visible (index cycle = step 0) and may
// end with a hall rise timed so the next accepted edge lands on the next
// window's step 0. The timeout is shortened to keep the run brief.
// -----------------------------------------------------------------------------
module tb_fan_tick_gen;

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned MAXP   = 12000;

  logic             clk;
  logic             rst;
  logic             hall;
  logic             fanclk;
  logic             index;
  logic             locked;
  logic [CNT_W-1:0] period;
  logic [8:0]       deg;

  int total;
  int bad;

  // Per-window observations filled by rev().
  int st_ticks;
  int st_idx;
  int st_idx0;
  int st_first;
  int st_min_sp;
  int st_max_sp;
  int st_max_deg;
  int st_deg_err;
  int st_unlocked;

  fan_tick_gen #(
    .CNT_W      (CNT_W),
    .MIN_GAP    (1000),
    .MIN_PERIOD (720),
    .MAX_PERIOD (MAXP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .hall   (hall),
    .fanclk (fanclk),
    .index  (index),
    .locked (locked),
    .period (period),
    .deg    (deg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one window of len cycles, optionally with short glitches starting at
  // steps g1/g2 and a 3-cycle hall pulse at the end, gathering observations.
  task automatic rev(input int len, input int g1, input int g2, input bit edge_end);
    int last;
    int sp;
    st_ticks = 0; st_idx = 0; st_idx0 = 0; st_first = -1;
    st_min_sp = 1 << 30; st_max_sp = 0; st_max_deg = 0;
    st_deg_err = 0; st_unlocked = 0; last = -1;
    for (int s = 0; s < len; s++) begin
      step();
      if (fanclk === 1'b1) begin
        st_ticks++;
        if (st_first < 0) st_first = s;
        if (last >= 0) begin
          sp = s - last;
          if (sp < st_min_sp) st_min_sp = sp;
          if (sp > st_max_sp) st_max_sp = sp;
        end
        last = s;
      end
      if (index === 1'b1) begin
        st_idx++;
        if (s == 0) st_idx0++;
      end
      if (int'(deg) > st_max_deg) st_max_deg = int'(deg);
      if (int'(deg) != st_ticks) st_deg_err++;
      if (locked !== 1'b1) st_unlocked++;
      hall = (edge_end && (s >= len - 3)) ||
             ((g1 >= 0) && (s >= g1) && (s < g1 + 2)) ||
             ((g2 >= 0) && (s >= g2) && (s < g2 + 2));
    end
  endtask

  task automatic test_reset();
    int idx_seen;
    rst = 1'b0;
    hall = 1'b1;
    repeat (3) step();
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked); end
    total++; if (fanclk !== 1'b0) begin bad++; $display("FAIL reset_fanclk got=%b want=0", fanclk); end
    total++; if (index !== 1'b0) begin bad++; $display("FAIL reset_index got=%b want=0", index); end
    total++; if (period !== 24'd0) begin bad++; $display("FAIL reset_period got=%0d want=0", period); end
    total++; if (deg !== 9'd0) begin bad++; $display("FAIL reset_deg got=%0d want=0", deg); end
    // Release with hall already high: must not be taken as an edge.
    rst = 1'b1;
    idx_seen = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (index !== 1'b0 || locked !== 1'b0) idx_seen++;
    end
    total++; if (idx_seen != 0) begin bad++; $display("FAIL release_quiet got=%0d want=0", idx_seen); end
  endtask

  task automatic test_lock();
    rev(1500, -1, -1, 1'b1);
    total++; if (st_unlocked != 1500) begin bad++; $display("FAIL lock_pre got=%0d want=1500", st_unlocked); end
    // First real edge only acquires.
    rev(3600, -1, -1, 1'b1);
    total++; if (st_unlocked != 3600) begin bad++; $display("FAIL lock_acq_unlocked got=%0d want=3600", st_unlocked); end
    total++; if (st_ticks != 0) begin bad++; $display("FAIL lock_acq_ticks got=%0d want=0", st_ticks); end
    // Second edge locks at 3600.
    rev(3600, -1, -1, 1'b1);
    total++; if (st_idx0 != 1 || st_idx != 1) begin bad++; $display("FAIL lock_index got=%0d/%0d want=1/1", st_idx0, st_idx); end
    total++; if (st_unlocked != 0) begin bad++; $display("FAIL lock_locked got=%0d want=0", st_unlocked); end
    total++; if (period !== 24'd3600) begin bad++; $display("FAIL lock_period got=%0d want=3600", period); end
    total++; if (st_ticks != 360) begin bad++; $display("FAIL lock_ticks got=%0d want=360", st_ticks); end
    total++; if (st_first != 9) begin bad++; $display("FAIL lock_first got=%0d want=9", st_first); end
    total++; if (st_min_sp != 10 || st_max_sp != 10) begin bad++; $display("FAIL lock_spacing got=%0d..%0d want=10..10", st_min_sp, st_max_sp); end
    total++; if (st_max_deg != 360) begin bad++; $display("FAIL lock_deg_max got=%0d want=360", st_max_deg); end
    total++; if (st_deg_err != 0) begin bad++; $display("FAIL lock_deg_track got=%0d want=0", st_deg_err); end
  endtask

  task automatic test_bounce();
    // Glitch rises 5 and 200 cycles after the accepted rise.
    rev(3600, 2, 197, 1'b1);
    total++; if (st_idx != 1 || st_idx0 != 1) begin bad++; $display("FAIL bounce_index got=%0d/%0d want=1/1", st_idx, st_idx0); end
    total++; if (period !== 24'd3600) begin bad++; $display("FAIL bounce_period got=%0d want=3600", period); end
    total++; if (st_ticks != 360) begin bad++; $display("FAIL bounce_ticks got=%0d want=360", st_ticks); end
    total++; if (st_unlocked != 0) begin bad++; $display("FAIL bounce_locked got=%0d want=0", st_unlocked); end
  endtask

  task automatic test_non_integer();
    // Still ticking at 3600 when the 1000-cycle edge arrives.
    rev(1000, -1, -1, 1'b1);
    total++; if (st_ticks != 100) begin bad++; $display("FAIL nonint_cut got=%0d want=100", st_ticks); end
    rev(1000, -1, -1, 1'b1);
    total++; if (period !== 24'd1000) begin bad++; $display("FAIL nonint_period got=%0d want=1000", period); end
    total++; if (st_ticks != 360) begin bad++; $display("FAIL nonint_ticks got=%0d want=360", st_ticks); end
    total++; if (st_min_sp != 2 || st_max_sp != 3) begin bad++; $display("FAIL nonint_spacing got=%0d..%0d want=2..3", st_min_sp, st_max_sp); end
    total++; if (st_first != 2) begin bad++; $display("FAIL nonint_first got=%0d want=2", st_first); end
    total++; if (st_idx0 != 1) begin bad++; $display("FAIL nonint_index got=%0d want=1", st_idx0); end
  endtask

  task automatic test_speed_up();
    // Long revolution at period 1000: ticks stop at 360.
    rev(3600, -1, -1, 1'b1);
    total++; if (st_ticks != 360) begin bad++; $display("FAIL cap_ticks got=%0d want=360", st_ticks); end
    total++; if (deg !== 9'd360) begin bad++; $display("FAIL cap_deg got=%0d want=360", deg); end
    // Period 3600 in effect, edge comes at 3000: cut at 300.
    rev(3000, -1, -1, 1'b1);
    total++; if (st_ticks != 300) begin bad++; $display("FAIL speed_cut_ticks got=%0d want=300", st_ticks); end
    total++; if (deg !== 9'd300) begin bad++; $display("FAIL speed_cut_deg got=%0d want=300", deg); end
    total++; if (period !== 24'd3600) begin bad++; $display("FAIL speed_old_period got=%0d want=3600", period); end
    rev(3000, -1, -1, 1'b1);
    total++; if (period !== 24'd3000) begin bad++; $display("FAIL speed_period got=%0d want=3000", period); end
    total++; if (st_ticks != 360) begin bad++; $display("FAIL speed_ticks got=%0d want=360", st_ticks); end
    total++; if (st_min_sp != 8 || st_max_sp != 9) begin bad++; $display("FAIL speed_spacing got=%0d..%0d want=8..9", st_min_sp, st_max_sp); end
    total++; if (st_first != 8) begin bad++; $display("FAIL speed_first got=%0d want=8", st_first); end
    total++; if (st_deg_err != 0) begin bad++; $display("FAIL speed_deg_track got=%0d want=0", st_deg_err); end
  endtask

  task automatic test_timeout();
    int t_unlock;
    int ticks;
    int late;
    int idx0;
    t_unlock = -1; ticks = 0; late = 0; idx0 = 0;
    hall = 1'b0;
    for (int s = 0; s < MAXP + 100; s++) begin
      step();
      if (s == 0 && index === 1'b1) idx0 = 1;
      if (t_unlock < 0 && locked !== 1'b1) t_unlock = s;
      if (fanclk === 1'b1) begin
        ticks++;
        if (t_unlock >= 0) late++;
      end
    end
    total++; if (idx0 != 1) begin bad++; $display("FAIL timeout_index got=%0d want=1", idx0); end
    total++; if (t_unlock != int'(MAXP)) begin bad++; $display("FAIL timeout_when got=%0d want=%0d", t_unlock, MAXP); end
    total++; if (ticks != 360 || late != 0) begin bad++; $display("FAIL timeout_ticks got=%0d/%0d want=360/0", ticks, late); end
    total++; if (period !== 24'd0) begin bad++; $display("FAIL timeout_period got=%0d want=0", period); end
    total++; if (deg !== 9'd0) begin bad++; $display("FAIL timeout_deg got=%0d want=0", deg); end
  endtask

  task automatic test_reset_mid();
    int found;
    rev(2000, -1, -1, 1'b1);
    rev(2000, -1, -1, 1'b1);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (fanclk === 1'b1) begin
        found = 1;
        break;
      end
    end
    total++; if (found != 1 || locked !== 1'b1) begin bad++; $display("FAIL mid_running got=%0d/%b want=1/1", found, locked); end
    rst = 1'b0;
    #1;
    total++; if (locked !== 1'b0 || fanclk !== 1'b0 || index !== 1'b0) begin bad++; $display("FAIL mid_abort_flags got=%b%b%b want=000", locked, fanclk, index); end
    total++; if (period !== 24'd0 || deg !== 9'd0) begin bad++; $display("FAIL mid_abort_regs got=%0d/%0d want=0/0", period, deg); end
    repeat (3) step();
    rst = 1'b1;
    rev(2000, -1, -1, 1'b1);
    total++; if (st_unlocked != 2000 || st_idx != 0) begin bad++; $display("FAIL mid_relock0 got=%0d/%0d want=2000/0", st_unlocked, st_idx); end
    rev(2000, -1, -1, 1'b1);
    total++; if (st_unlocked != 2000 || st_idx != 0) begin bad++; $display("FAIL mid_relock1 got=%0d/%0d want=2000/0", st_unlocked, st_idx); end
    rev(2000, -1, -1, 1'b0);
    total++; if (st_idx0 != 1 || st_unlocked != 0) begin bad++; $display("FAIL mid_relock2 got=%0d/%0d want=1/0", st_idx0, st_unlocked); end
    total++; if (period !== 24'd2000) begin bad++; $display("FAIL mid_period got=%0d want=2000", period); end
    total++; if (st_ticks != 360) begin bad++; $display("FAIL mid_ticks got=%0d want=360", st_ticks); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    hall  = 1'b0;
    test_reset();
    test_lock();
    test_bounce();
    test_non_integer();
    test_speed_up();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
